// File: rtl/serdes_rx_buffer.sv
// Receive half of the serial link: LSB-first deserializer feeding a circular FIFO,
// drained by a level-request to single-pop pulse generator.
module serdes_rx_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  serial_in_i,
  input  logic                  enable_i,
  input  logic                  start_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  word_valid_o,
  input  logic                  rd_req_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  rd_pop_o,
  output logic                  fifo_full_o,
  output logic                  fifo_empty_o,
  output logic                  overflow_o
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    PG_ARMED,
    PG_SPENT
  } pg_state_t;

  // ---------------- deserializer ----------------
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-2:0] shift_reg;
  logic [DATA_WIDTH-1:0] word_next;
  logic                  word_done;

  // The top bit never needs storage: it is taken straight from the line on the completing edge.
  always_comb begin
    word_next = {serial_in_i, shift_reg};
    word_done = enable_i & ~start_i & (bit_cnt == LAST_BIT);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bit_cnt      <= '0;
      shift_reg    <= '0;
      word_o       <= '0;
      word_valid_o <= 1'b0;
    end else begin
      word_valid_o <= 1'b0;
      if (enable_i) begin
        if (start_i) begin
          shift_reg <= (DATA_WIDTH-1)'(serial_in_i);
          bit_cnt   <= BIT_W'(1);
        end else if (word_done) begin
          word_o       <= word_next;
          word_valid_o <= 1'b1;
          bit_cnt      <= '0;
        end else if (bit_cnt != '0) begin
          shift_reg[bit_cnt] <= serial_in_i;
          bit_cnt            <= bit_cnt + BIT_W'(1);
        end
      end
    end
  end

  // ---------------- FIFO ----------------
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  do_push;
  logic                  do_pop;

  always_comb begin
    fifo_full_o  = (count == FULL_CNT);
    fifo_empty_o = (count == '0);
    rd_valid_o   = ~fifo_empty_o;
    rd_data_o    = mem[rd_ptr];
    // Fullness is judged before the edge, so a same-cycle pop cannot make room.
    do_push      = word_done & ~fifo_full_o;
    do_pop       = rd_pop_o;
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= word_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      overflow_o <= word_done & fifo_full_o;
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- pulse generator ----------------
  pg_state_t pg_state;
  pg_state_t pg_next;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pg_state <= PG_ARMED;
    end else begin
      pg_state <= pg_next;
    end
  end

  always_comb begin
    pg_next = pg_state;
    case (pg_state)
      PG_ARMED: if (rd_pop_o)  pg_next = PG_SPENT;
      PG_SPENT: if (!rd_req_i) pg_next = PG_ARMED;
      default:                 pg_next = PG_ARMED;
    endcase
  end

  always_comb begin
    rd_pop_o = rd_req_i & (pg_state == PG_ARMED) & ~fifo_empty_o;
  end

endmodule

// File: tb/tb_serdes_rx_buffer.sv
// Randomized plus directed bench for serdes_rx_buffer against a queue-based reference model.
module tb_serdes_rx_buffer;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          serial_in_i;
  logic          enable_i;
  logic          start_i;
  logic [DW-1:0] word_o;
  logic          word_valid_o;
  logic          rd_req_i;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          rd_pop_o;
  logic          fifo_full_o;
  logic          fifo_empty_o;
  logic          overflow_o;

  serdes_rx_buffer #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .serial_in_i (serial_in_i),
    .enable_i    (enable_i),
    .start_i     (start_i),
    .word_o      (word_o),
    .word_valid_o(word_valid_o),
    .rd_req_i    (rd_req_i),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .rd_pop_o    (rd_pop_o),
    .fifo_full_o (fifo_full_o),
    .fifo_empty_o(fifo_empty_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state
  logic [DW-1:0] q [$];
  int            m_cnt;
  logic [DW-1:0] m_partial;
  logic [DW-1:0] m_word;
  bit            m_wv;
  bit            m_ovf;
  bit            m_armed;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_pops   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt     = 0;
    m_partial = '0;
    m_word    = '0;
    m_wv      = 0;
    m_ovf     = 0;
    m_armed   = 1;
  endtask

  task automatic check_reset_values();
    check("rst_word",   word_o,       0);
    check("rst_wvalid", word_valid_o, 0);
    check("rst_ovf",    overflow_o,   0);
    check("rst_empty",  fifo_empty_o, 1);
    check("rst_full",   fifo_full_o,  0);
    check("rst_rvalid", rd_valid_o,   0);
    check("rst_pop",    rd_pop_o,     0);
  endtask

  // One clock: drive at the falling edge, check, then advance the model over the rising edge.
  task automatic step(input bit ser, input bit en, input bit st);
    bit exp_pop;
    bit was_full;
    serial_in_i = ser;
    enable_i    = en;
    start_i     = st;
    #1;
    exp_pop = rd_req_i && m_armed && (q.size() != 0);
    check("empty",  fifo_empty_o, q.size() == 0);
    check("full",   fifo_full_o,  q.size() == DEPTH);
    check("rvalid", rd_valid_o,   q.size() != 0);
    if (q.size() != 0) check("rdata", rd_data_o, q[0]);
    check("pop",    rd_pop_o,     exp_pop);
    check("word",   word_o,       m_word);
    check("wvalid", word_valid_o, m_wv);
    check("ovf",    overflow_o,   m_ovf);
    @(posedge clk_i);
    was_full = (q.size() == DEPTH);
    m_wv  = 0;
    m_ovf = 0;
    if (exp_pop) begin
      void'(q.pop_front());
      n_pops++;
    end
    if (exp_pop) m_armed = 0;
    else if (!rd_req_i) m_armed = 1;
    if (en) begin
      if (st) begin
        m_partial = '0;
        m_partial[0] = ser;
        m_cnt = 1;
      end else if (m_cnt > 0) begin
        m_partial[m_cnt] = ser;
        m_cnt++;
        if (m_cnt == DW) begin
          m_word = m_partial;
          m_wv   = 1;
          m_cnt  = 0;
          if (was_full) m_ovf = 1;
          else q.push_back(m_partial);
        end
      end
    end
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int i = 0; i < DW; i++) step(w[i], 1, i == 0);
  endtask

  initial begin
    logic [DW-1:0] pat;
    rst_n_i     = 1'b0;
    serial_in_i = 1'b0;
    enable_i    = 1'b0;
    start_i     = 1'b0;
    rd_req_i    = 1'b0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    check_reset_values();
    rst_n_i = 1'b1;

    // Single word, no reads
    send_word(8'hA5);
    check("a5_wvalid", word_valid_o, 1);
    check("a5_word",   word_o,       8'hA5);
    check("a5_rdata",  rd_data_o,    8'hA5);
    idle(2);
    rd_req_i = 1; step(0, 0, 0); rd_req_i = 0; idle(1);

    // Held request pops exactly once
    send_word(8'h11);
    send_word(8'h22);
    n_pops = 0;
    rd_req_i = 1; idle(5);
    check("hold_pops", n_pops, 1);
    check("hold_head", rd_data_o, 8'h22);
    rd_req_i = 0; idle(1);
    rd_req_i = 1; idle(2);
    check("second_pop_empty", fifo_empty_o, 1);
    rd_req_i = 0; idle(1);

    // Request waiting on an empty FIFO
    rd_req_i = 1; idle(3);
    n_pops = 0;
    send_word(8'h3C);
    check("wait_pop_now", rd_pop_o, 1);
    idle(3);
    check("wait_pops", n_pops, 1);
    check("wait_empty", fifo_empty_o, 1);
    rd_req_i = 0; idle(1);

    // Overflow and wrap
    for (int w = 1; w <= 5; w++) begin
      pat = DW'(w);
      send_word(pat);
      if (w == 4) check("full_after_4", fifo_full_o, 1);
    end
    check("ovf_on_5", overflow_o, 1);
    for (int w = 1; w <= 4; w++) begin
      check("drain_data", rd_data_o, w);
      rd_req_i = 1; step(0, 0, 0);
      rd_req_i = 0; step(0, 0, 0);
    end
    check("drain_empty", fifo_empty_o, 1);

    // Gap then restart mid-word
    pat = 8'h5A;
    for (int i = 0; i < 3; i++) step(pat[i], 1, i == 0);
    idle(3);
    for (int i = 3; i < 5; i++) step(pat[i], 1, 0);
    send_word(8'hF0);
    check("restart_word", word_o, 8'hF0);
    check("restart_head", rd_data_o, 8'hF0);
    rd_req_i = 1; step(0, 0, 0); rd_req_i = 0; idle(1);

    // Asynchronous reset mid-word
    send_word(8'h77);
    pat = 8'hC3;
    for (int i = 0; i < 4; i++) step(pat[i], 1, i == 0);
    #2 rst_n_i = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step(1, 1, 0);
    send_word(8'h96);
    check("post_rst_word", word_o, 8'h96);
    rd_req_i = 1; step(0, 0, 0); rd_req_i = 0; idle(1);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      bit en;
      bit st;
      if ($urandom_range(0, 3) == 0) rd_req_i = ~rd_req_i;
      en = ($urandom_range(0, 3) != 0);
      st = en && ((m_cnt == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0));
      step(1'($urandom), en, st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
